// File: rtl/multi_motor_drive_if.sv
// multi_motor_drive_if: per-channel command inputs and motor drive outputs.
interface multi_motor_drive_if #(parameter int N_CH = 2, parameter int PWM_W = 10, parameter int PER_W = 32);
  logic [N_CH-1:0] enable;
  logic [N_CH-1:0] dir;
  logic [N_CH*PWM_W-1:0] speed;
  logic [N_CH*PER_W-1:0] period;
  logic [N_CH*3-1:0] motor;
  logic [N_CH*PWM_W-1:0] duty_now;
  logic [N_CH*3-1:0] step_idx;
  logic frame_tick;
  modport master(output enable, dir, speed, period, input motor, duty_now, step_idx, frame_tick);
  modport slave(input enable, dir, speed, period, output motor, duty_now, step_idx, frame_tick);
endinterface

// File: rtl/multi_motor_drive.sv
// multi_motor_drive: N-channel 3-phase commutation with shared PWM frame and slew-limited duty.
module multi_motor_drive #(
  parameter int N_CH = 2,
  parameter int PWM_W = 10,
  parameter int PWM_TOP = 999,
  parameter int PER_W = 32,
  parameter int RAMP_STEP = 8,
  parameter logic [PER_W-1:0] MAX_PERIOD = 32'h7fffffff
) (
  input logic clk,
  input logic rst_n,
  multi_motor_drive_if.slave bus
);
  localparam logic [PWM_W-1:0] TOP = PWM_W'(PWM_TOP);
  localparam logic [PWM_W-1:0] FULL = PWM_W'(PWM_TOP + 1);
  localparam logic [PWM_W-1:0] RS = PWM_W'(RAMP_STEP);
  logic [PWM_W-1:0] pwm_cnt, pwm_nxt;
  logic ft;
  assign pwm_nxt = (pwm_cnt == TOP) ? '0 : pwm_cnt + 1'b1;
  assign bus.frame_tick = ft;
  // frame_tick is registered from the next count so it coincides with pwm_cnt==PWM_TOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_cnt <= '0;
      ft <= 1'b0;
    end else begin
      pwm_cnt <= pwm_nxt;
      ft <= (pwm_nxt == TOP);
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [PWM_W-1:0] spd, tgt, duty, duty_nxt;
    logic [PER_W-1:0] lat, cnt, per_in;
    logic [2:0] step, step_nxt, pat, mot;
    logic stopped, wrap, pwm_on;
    assign spd = bus.speed[i*PWM_W +: PWM_W];
    assign per_in = bus.period[i*PER_W +: PER_W];
    assign tgt = !bus.enable[i] ? '0 : (spd > FULL ? FULL : spd);
    assign duty_nxt = duty < tgt ? (tgt - duty > RS ? duty + RS : tgt)
                                 : (duty - tgt > RS ? duty - RS : tgt);
    assign stopped = !bus.enable[i] || lat >= MAX_PERIOD || lat == '0;
    assign wrap = cnt == lat - 1'b1;
    assign pwm_on = pwm_cnt < duty;
    assign step_nxt = bus.dir[i] ? (step == 3'd0 ? 3'd5 : step - 3'd1)
                                 : (step == 3'd5 ? 3'd0 : step + 3'd1);
    assign pat = step == 3'd0 ? 3'b001 : step == 3'd1 ? 3'b011 : step == 3'd2 ? 3'b010 :
                 step == 3'd3 ? 3'b110 : step == 3'd4 ? 3'b100 : 3'b101;
    assign bus.motor[i*3 +: 3] = mot;
    assign bus.duty_now[i*PWM_W +: PWM_W] = duty;
    assign bus.step_idx[i*3 +: 3] = step;
    // period is only sampled while stopped or at a step boundary so a step never gets cut short
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        duty <= '0;
        lat <= MAX_PERIOD;
        cnt <= '0;
        step <= '0;
        mot <= '0;
      end else begin
        if (ft) duty <= duty_nxt;
        if (stopped || wrap) begin
          lat <= per_in;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        if (!stopped && wrap) step <= step_nxt;
        mot <= stopped ? 3'b000 : pat & {3{pwm_on}};
      end
  end
endmodule

// File: tb/tb_multi_motor_drive.sv
// tb_multi_motor_drive: random and directed stimulus against a cycle-count reference model with scoreboard.
module tb_multi_motor_drive;
  localparam int N = 2, PW = 10, TOPV = 9, RS = 2, FULLV = TOPV + 1;
  localparam logic [31:0] MAXP = 32'h7fffffff;
  typedef struct packed {
    logic [N*3-1:0] motor;
    logic [N*PW-1:0] duty;
    logic [N*3-1:0] step;
    logic ft;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  multi_motor_drive_if #(.N_CH(N), .PWM_W(PW), .PER_W(32)) bus();
  multi_motor_drive #(.N_CH(N), .PWM_W(PW), .PWM_TOP(TOPV), .PER_W(32), .RAMP_STEP(RS),
                      .MAX_PERIOD(MAXP)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  exp_t me, ce;
  int total = 0, bad = 0;
  int k, pb, tgt, spd, cnt_on;
  bit en, stp;
  int md[N], ms[N], mel[N];
  logic [31:0] mlat[N];
  logic [2:0] pat_tbl[6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  logic [31:0] pers[8] = '{0, 1, 2, 3, 5, 7, MAXP, 32'hffffffff};
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: elapsed-cycle bookkeeping per channel, one expected output set per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      q.delete();
      for (int c = 0; c < N; c++) begin
        md[c] = 0; ms[c] = 0; mel[c] = 0; mlat[c] = MAXP;
      end
    end else begin
      pb = k % FULLV;
      for (int c = 0; c < N; c++) begin
        en = bus.enable[c];
        stp = !en || mlat[c] >= MAXP || mlat[c] == 0;
        me.motor[c*3 +: 3] = stp ? 3'b000 : (pb < md[c] ? pat_tbl[ms[c]] : 3'b000);
        if (pb == TOPV) begin
          spd = int'(bus.speed[c*PW +: PW]);
          tgt = en ? (spd > FULLV ? FULLV : spd) : 0;
          if (tgt > md[c]) md[c] = md[c] + (tgt - md[c] > RS ? RS : tgt - md[c]);
          else md[c] = md[c] - (md[c] - tgt > RS ? RS : md[c] - tgt);
        end
        if (stp) begin
          mlat[c] = bus.period[c*32 +: 32];
          mel[c] = 0;
        end else begin
          mel[c]++;
          if (mel[c] == int'(mlat[c])) begin
            mel[c] = 0;
            ms[c] = bus.dir[c] ? (ms[c] + 5) % 6 : (ms[c] + 1) % 6;
            mlat[c] = bus.period[c*32 +: 32];
          end
        end
        me.duty[c*PW +: PW] = PW'(md[c]);
        me.step[c*3 +: 3] = 3'(ms[c]);
      end
      k++;
      me.ft = (k % FULLV) == TOPV;
      q.push_back(me);
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      ce = q.pop_front();
      chk("frame_tick", int'(bus.frame_tick), int'(ce.ft));
      for (int c = 0; c < N; c++) begin
        chk($sformatf("motor%0d", c), int'(bus.motor[c*3 +: 3]), int'(ce.motor[c*3 +: 3]));
        chk($sformatf("duty%0d", c), int'(bus.duty_now[c*PW +: PW]), int'(ce.duty[c*PW +: PW]));
        chk($sformatf("step%0d", c), int'(bus.step_idx[c*3 +: 3]), int'(ce.step[c*3 +: 3]));
      end
    end
  end
  task automatic set_ch(input int c, input bit e, input bit d, input int s, input logic [31:0] p);
    @(negedge clk);
    bus.enable[c] = e;
    bus.dir[c] = d;
    bus.speed[c*PW +: PW] = PW'(s);
    bus.period[c*32 +: 32] = p;
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_motor"}, int'(bus.motor), 0);
    chk({nm, "_duty"}, int'(bus.duty_now), 0);
    chk({nm, "_step"}, int'(bus.step_idx), 0);
    chk({nm, "_tick"}, int'(bus.frame_tick), 0);
  endtask
  initial begin
    bus.enable = '0;
    bus.dir = '0;
    bus.speed = '0;
    bus.period = {N{MAXP}};
    #1;
    chk_zero("reset");
    wait_cyc(2);
    rst_n = 1'b1;
    set_ch(0, 1, 0, 10, MAXP);
    wait_cyc(60);
    chk("ramp_full", int'(bus.duty_now[PW-1:0]), 10);
    set_ch(0, 1, 0, 15, MAXP);
    wait_cyc(30);
    chk("ramp_clamp", int'(bus.duty_now[PW-1:0]), 10);
    set_ch(0, 1, 0, 4, MAXP);
    wait_cyc(40);
    set_ch(0, 1, 0, 4, 5);
    wait_cyc(20);
    cnt_on = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.motor[2:0] != 3'b000) cnt_on++;
    end
    chk("on_per_frame", cnt_on, 4);
    wait_cyc(20);
    set_ch(0, 1, 1, 4, 5);
    wait_cyc(17);
    set_ch(0, 1, 0, 4, 5);
    wait_cyc(2);
    set_ch(0, 1, 1, 4, 5);
    wait_cyc(15);
    set_ch(0, 1, 0, 4, 20);
    wait_cyc(60);
    set_ch(0, 1, 0, 4, MAXP);
    wait_cyc(30);
    set_ch(0, 1, 0, 10, 5);
    wait_cyc(40);
    chk("ch1_idle_duty", int'(bus.duty_now[2*PW-1:PW]), 0);
    chk("ch1_idle_motor", int'(bus.motor[5:3]), 0);
    set_ch(1, 1, 0, 6, 7);
    wait_cyc(100);
    set_ch(0, 1, 0, 6, 5);
    wait_cyc(40);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    wait_cyc(2);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    wait_cyc(30);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 19) == 0) begin
          bus.enable[c] = $urandom_range(0, 5) != 0;
          bus.dir[c] = 1'($urandom_range(0, 1));
          bus.speed[c*PW +: PW] = PW'($urandom_range(0, 4) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 12));
          bus.period[c*32 +: 32] = pers[$urandom_range(0, 7)];
        end
    end
    wait_cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_motor_drive.md
Name: multi_motor_drive

Overview:
- Parametrised successor to the single-channel speed-apply block.
- Drives N_CH independent 3-phase motor outputs from per-channel speed (PWM duty) and step-period commands.
- Adds a shared PWM frame counter, per-channel duty slew limiting, direction control, enable gating and glitch-free period updates at step boundaries.
- Sits between the speed/force control logic and the motor driver pins.

Parameters:
N_CH, 2, number of motor channels
PWM_W, 10, width of speed/duty value
PWM_TOP, 999, PWM frame length minus 1 (100 kHz frame at 100 MHz clk)
PER_W, 32, width of step-period value
RAMP_STEP, 8, max duty change per PWM frame
MAX_PERIOD, 32'h7fffffff, period value at or above which a channel is stopped

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  N_CH  per-channel run enable
dir  in  N_CH  per-channel direction: 0 forward, 1 reverse
speed  in  N_CH*PWM_W  target duty per channel, ch0 in LSBs
period  in  N_CH*PER_W  step period in clk cycles per channel, ch0 in LSBs
motor  out  N_CH*3  phase drive outputs, ch0 in bits [2:0]
duty_now  out  N_CH*PWM_W  current ramped duty per channel
step_idx  out  N_CH*3  current commutation step 0..5 per channel
frame_tick  out  1  one-cycle pulse at end of each PWM frame

Behaviour:
- Reset (async, rst_n=0): all outputs 0; pwm_cnt=0; per_cnt=0; step_idx=0; latched period=MAX_PERIOD. The first rising clk edge after rst_n rises resumes counting.
- PWM counter pwm_cnt: counts 0..PWM_TOP and wraps to 0.
- frame_tick: registered, high for exactly the cycle in which pwm_cnt==PWM_TOP.
- Duty ramp, per channel:
  - target = enable ? min(speed, PWM_TOP+1) : 0.
  - On each frame_tick cycle, duty_now moves toward target by at most RAMP_STEP, never overshooting.
  - The new duty applies from pwm_cnt=0 of the next frame.
- pwm_on = (pwm_cnt < duty_now).
  - duty_now=0 gives never on.
  - duty_now=PWM_TOP+1 gives always on.
- Step timer, per channel:
  - The channel is stopped when enable=0, or latched period >= MAX_PERIOD, or latched period == 0.
  - Stopped: per_cnt held at 0, step_idx held, period input re-latched every cycle.
  - Running: per_cnt increments each cycle. When per_cnt == latched_period-1: per_cnt<=0, step_idx advances, period input re-latched.
  - Advance direction: dir=0 gives (step_idx+1) mod 6; dir=1 gives (step_idx+5) mod 6.
  - dir is sampled only at the advance.
  - A period change mid-step takes effect only at the next step boundary; the current step always completes with the old period.
  - Leaving the stopped state: per_cnt starts at 0 with the newly latched period, and step_idx resumes from its held value.
- Commutation table (step -> phase pattern [2:0]): 0:001, 1:011, 2:010, 3:110, 4:100, 5:101.
- motor output:
  - motor = table(step_idx) AND {3{pwm_on}}.
  - Forced to 000 when the channel is stopped or enable=0.
  - Registered, 1-cycle latency from pwm_cnt/step_idx.
  - Never has all three bits high.
- enable deassert: motor goes 000 on the next clk edge. duty_now ramps down toward 0 on subsequent frame_ticks. step_idx is held.
- speed > PWM_TOP+1: clamped to PWM_TOP+1.
- Channels are fully independent and share only pwm_cnt and frame_tick.

Test Plan:
Bench parameters for all scenarios: PWM_TOP=9, RAMP_STEP=2, N_CH=2.
1. Reset mid-run (ch0 running, period=5, duty=6), pull rst_n low between clk edges -> motor, duty_now, step_idx and frame_tick all 0 immediately without a clk edge; they stay 0 until rst_n rises.
2. Duty ramp, ch0 enable=1, speed=10, period=MAX_PERIOD -> duty_now 0,2,4,6,8,10 on successive frame_ticks, motor stays 000; then speed=15 -> duty_now clamps at 10.
3. Duty shape, ch0 speed=4 (settled), period=5, dir=0 -> motor nonzero exactly 4 of every 10 cycles. step_idx goes 0,1,2,3,4,5,0 every 5 cycles. The motor pattern follows the table (001,011,010,...).
4. Reverse, dir=1 from step_idx=0, period=5 -> step_idx 5,4,3 at 5-cycle intervals. Toggling dir mid-step changes direction only at the next boundary.
5. Period change and stop:
   - period changes 5->20 two cycles into a step -> that step ends 3 cycles later; the next step lasts 20 cycles.
   - period=32'h7fffffff -> step_idx frozen and motor=000.
   - period restored to 5 -> stepping resumes from the frozen index.
6. Independence, ch0 running (period=5, speed=10), ch1 enable=0 -> ch1 motor=000 and duty_now[1]=0 throughout. Then ch1 enable=1, speed=6, period=7 -> ch1 ramps and steps without affecting ch0 timing.
